// File: rtl/hazard_stall_unit_pkg.sv
// Shared types for the hazard/stall interlock.
//   regNum_t       architectural register number
//   sbEntry_t      one scoreboard entry {vld, rd, ld}
//   stallAction_e  the single action the interlock takes in a given cycle
//   makeEntry      builds an entry; x0 and non-writing instructions are never tracked
//   visibleRd      rd as seen by the forwarding compare (0 for an invalid entry)
package hazard_stall_unit_pkg;

  localparam int RegNumWidth = 5;

  typedef logic [RegNumWidth-1:0] regNum_t;

  typedef struct packed {
    logic    vld;
    regNum_t rd;
    logic    ld;
  } sbEntry_t;

  localparam sbEntry_t SbEmpty = '0;

  typedef enum logic [1:0] {
    ActIssue,
    ActFlush,
    ActLoadUse,
    ActFreeze
  } stallAction_e;

  function automatic sbEntry_t makeEntry(input logic valid, input logic we,
                                         input regNum_t rd, input logic isLoad);
    sbEntry_t e;
    e.vld = valid & we & (rd != '0);
    e.rd  = rd;
    e.ld  = isLoad;
    return e;
  endfunction

  function automatic regNum_t visibleRd(input sbEntry_t e);
    return e.vld ? e.rd : '0;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_sb_stage_reg.sv
// One scoreboard entry (EX, MEM or WB slot).
//   clk, rstn  clock and asynchronous active-low reset
//   load       capture d this cycle
//   clear      write an empty entry (takes priority over load)
//   d / q      entry in / registered entry out
// With neither load nor clear the entry holds, which is how a freeze is implemented.
module sb_stage_reg
  import hazard_stall_unit_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     load,
  input  logic     clear,
  input  sbEntry_t d,
  output sbEntry_t q
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= SbEmpty;
    end else if (clear) begin
      q <= SbEmpty;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Producer-side interlock for the 5-stage pipeline.
// Tracks in-flight destination registers in EX/MEM/WB and decides each cycle whether
// the decode instruction may issue.
//   clk, rstn                       clock, asynchronous active-low reset
//   id_valid/id_rs1/id_rs2          decode instruction and its sources
//   id_use_rs1/id_use_rs2           which sources are really read
//   id_rd/id_we/id_is_load          decode destination and its kind
//   flush                           kill the decode instruction (branch taken in EX)
//   mem_busy                        data memory wait state
//   hold_front                      hold PC and IF/ID
//   bubble_ex                       write a NOP into ID/EX
//   freeze                          hold ID/EX, EX/MEM, MEM/WB
//   ex_rd/mem_rd/wb_rd              tracked rd per stage, 0 when the slot is empty
//   stall_cnt                       saturating count of cycles with hold_front=1
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_we,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             mem_busy,
  output logic             hold_front,
  output logic             bubble_ex,
  output logic             freeze,
  output logic [4:0]       ex_rd,
  output logic [4:0]       mem_rd,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  sbEntry_t     exEntry;
  sbEntry_t     memEntry;
  sbEntry_t     wbEntry;
  sbEntry_t     exNext;
  stallAction_e action;
  logic         rs1Hit;
  logic         rs2Hit;
  logic         hazardLu;
  logic         pipeAdvance;
  logic         exClear;
  logic         unusedWbLd;

  // Only a load sitting in EX can stall: its data is not ready for forwarding yet.
  // x0 never matches because an x0 destination is never marked valid.
  always_comb begin
    rs1Hit   = id_use_rs1 & (id_rs1 == exEntry.rd);
    rs2Hit   = id_use_rs2 & (id_rs2 == exEntry.rd);
    hazardLu = id_valid & exEntry.vld & exEntry.ld & (rs1Hit | rs2Hit);
    exNext   = makeEntry(id_valid, id_we, id_rd, id_is_load);
  end

  // A memory wait outranks everything; a flush kills the decode instruction, so it
  // outranks the load-use hold (a dead instruction has nothing to wait for).
  always_comb begin
    action = ActIssue;
    if (mem_busy) begin
      action = ActFreeze;
    end else if (flush) begin
      action = ActFlush;
    end else if (hazardLu) begin
      action = ActLoadUse;
    end
  end

  // hold_front and bubble_ex are gated by rstn so an asserted reset drops a stall
  // at once; freeze keeps following mem_busy even in reset.
  always_comb begin
    hold_front  = 1'b0;
    bubble_ex   = 1'b0;
    freeze      = 1'b0;
    pipeAdvance = 1'b1;
    exClear     = 1'b0;
    case (action)
      ActFreeze: begin
        freeze      = 1'b1;
        hold_front  = rstn;
        pipeAdvance = 1'b0;
      end
      ActFlush: begin
        bubble_ex = rstn;
        exClear   = 1'b1;
      end
      ActLoadUse: begin
        hold_front = rstn;
        bubble_ex  = rstn;
        exClear    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  sb_stage_reg exStage (
    .clk  (clk),
    .rstn (rstn),
    .load (pipeAdvance),
    .clear(exClear),
    .d    (exNext),
    .q    (exEntry)
  );

  sb_stage_reg memStage (
    .clk  (clk),
    .rstn (rstn),
    .load (pipeAdvance),
    .clear(1'b0),
    .d    (exEntry),
    .q    (memEntry)
  );

  sb_stage_reg wbStage (
    .clk  (clk),
    .rstn (rstn),
    .load (pipeAdvance),
    .clear(1'b0),
    .d    (memEntry),
    .q    (wbEntry)
  );

  // The load flag of the WB slot is kept only for a uniform entry format.
  assign unusedWbLd = wbEntry.ld;

  always_comb begin
    ex_rd  = visibleRd(exEntry);
    mem_rd = visibleRd(memEntry);
    wb_rd  = visibleRd(wbEntry);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (hold_front && (stall_cnt != CntMax)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
